// File: rtl/accuracy_tracker.sv
// Run-time accuracy scoreboard: scores one (result, label) pair per batch_done
// pulse during a run and keeps total/correct/invalid and per-class seen/hit counts.
module accuracy_tracker #(
  parameter int NUM_CLASSES = 10,
  parameter int CLASS_W     = 4,
  parameter int CNT_W       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               batch_done,
  input  logic [CLASS_W-1:0] result,
  input  logic [CLASS_W-1:0] label,
  output logic [CNT_W-1:0]   sample_idx,
  output logic [CNT_W-1:0]   total_count,
  output logic [CNT_W-1:0]   correct_count,
  output logic [CNT_W-1:0]   invalid_count,
  input  logic [CLASS_W-1:0] rd_class,
  output logic [CNT_W-1:0]   rd_seen,
  output logic [CNT_W-1:0]   rd_hits,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  // Handshake: start and batch_done are single-cycle strobes sampled on the
  // rising edge; result/label are qualified only by batch_done (no back-pressure).

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CLASS_W:0] NCLS = (CLASS_W + 1)'(NUM_CLASSES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   correct_q, correct_d;
  logic [CNT_W-1:0]   invalid_q, invalid_d;
  logic [CNT_W-1:0]   seen_q [NUM_CLASSES];
  logic [CNT_W-1:0]   seen_d [NUM_CLASSES];
  logic [CNT_W-1:0]   hits_q [NUM_CLASSES];
  logic [CNT_W-1:0]   hits_d [NUM_CLASSES];
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic cls_legal(input logic [CLASS_W-1:0] c);
    return {1'b0, c} < NCLS;
  endfunction

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    total_d   = total_q;
    correct_d = correct_q;
    invalid_d = invalid_q;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      seen_d[c] = seen_q[c];
      hits_d[c] = hits_q[c];
    end

    // start wins over a coincident batch_done in every state
    if (start) begin
      len_d     = num_samples;
      idx_d     = '0;
      total_d   = '0;
      correct_d = '0;
      invalid_d = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        seen_d[c] = '0;
        hits_d[c] = '0;
      end
      state_d = (num_samples == '0) ? S_DONE : S_RUN;
    end else if (state_q == S_RUN && batch_done) begin
      total_d = sat_inc(total_q);
      if (idx_q < len_q) idx_d = idx_q + CNT_W'(1);
      if (!cls_legal(result) || !cls_legal(label)) begin
        invalid_d = sat_inc(invalid_q);
      end else begin
        seen_d[label] = sat_inc(seen_q[label]);
        if (result == label) begin
          correct_d     = sat_inc(correct_q);
          hits_d[label] = sat_inc(hits_q[label]);
        end
      end
      if (total_d == len_q) state_d = S_DONE;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      total_q   <= '0;
      correct_q <= '0;
      invalid_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        seen_q[c] <= '0;
        hits_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      total_q   <= total_d;
      correct_q <= correct_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        seen_q[c] <= seen_d[c];
        hits_q[c] <= hits_d[c];
      end
    end
  end

  always_comb begin
    rd_seen = '0;
    rd_hits = '0;
    if (cls_legal(rd_class)) begin
      rd_seen = seen_q[rd_class];
      rd_hits = hits_q[rd_class];
    end
  end

  assign sample_idx    = idx_q;
  assign total_count   = total_q;
  assign correct_count = correct_q;
  assign invalid_count = invalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_accuracy_tracker.sv
// Directed bench for accuracy_tracker: a default-width instance and a CNT_W=3
// instance, both checked every cycle against a spec-level model.
module tb_accuracy_tracker;

  logic       clk;
  logic       rst;
  logic       start_v [2];
  logic       bd_v    [2];
  logic [9:0] ns_v    [2];
  logic [3:0] res_v   [2];
  logic [3:0] lab_v   [2];
  logic [3:0] rdc_v   [2];

  logic [9:0] o0_idx, o0_tot, o0_cor, o0_inv, o0_seen, o0_hits;
  logic       o0_busy, o0_done;
  logic [1:0] o0_st;
  logic [2:0] o1_idx, o1_tot, o1_cor, o1_inv, o1_seen, o1_hits;
  logic       o1_busy, o1_done;
  logic [1:0] o1_st;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  accuracy_tracker u_d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .num_samples(ns_v[0]),
    .batch_done(bd_v[0]), .result(res_v[0]), .label(lab_v[0]),
    .sample_idx(o0_idx), .total_count(o0_tot), .correct_count(o0_cor),
    .invalid_count(o0_inv), .rd_class(rdc_v[0]), .rd_seen(o0_seen),
    .rd_hits(o0_hits), .busy(o0_busy), .done(o0_done), .state_dbg(o0_st)
  );

  accuracy_tracker #(.CNT_W(3)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .num_samples(ns_v[1][2:0]),
    .batch_done(bd_v[1]), .result(res_v[1]), .label(lab_v[1]),
    .sample_idx(o1_idx), .total_count(o1_tot), .correct_count(o1_cor),
    .invalid_count(o1_inv), .rd_class(rdc_v[1]), .rd_seen(o1_seen),
    .rd_hits(o1_hits), .busy(o1_busy), .done(o1_done), .state_dbg(o1_st)
  );

  // ---------------- model (0=idle, 1=run, 2=done) ----------------
  int m_st [2], m_len [2], m_tot [2], m_cor [2], m_inv [2], m_idx [2];
  int m_seen [2][16];
  int m_hit  [2][16];
  int cmax   [2] = '{1023, 7};

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_clear(int i, bit full);
    m_tot[i] = 0; m_cor[i] = 0; m_inv[i] = 0; m_idx[i] = 0;
    for (int c = 0; c < 16; c++) begin
      m_seen[i][c] = 0;
      m_hit[i][c]  = 0;
    end
    if (full) begin
      m_st[i]  = 0;
      m_len[i] = 0;
    end
  endtask

  always @(negedge rst) begin
    m_clear(0, 1'b1);
    m_clear(1, 1'b1);
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        int ns, r, l;
        ns = (i == 0) ? int'(ns_v[0]) : int'(ns_v[1][2:0]);
        r  = int'(res_v[i]);
        l  = int'(lab_v[i]);
        if (start_v[i]) begin
          m_clear(i, 1'b0);
          m_len[i] = ns;
          m_st[i]  = (ns == 0) ? 2 : 1;
        end else if (m_st[i] == 1 && bd_v[i]) begin
          m_tot[i] = sat(m_tot[i] + 1, cmax[i]);
          if (m_idx[i] < m_len[i]) m_idx[i]++;
          if (r >= 10 || l >= 10) begin
            m_inv[i] = sat(m_inv[i] + 1, cmax[i]);
          end else begin
            m_seen[i][l] = sat(m_seen[i][l] + 1, cmax[i]);
            if (r == l) begin
              m_cor[i]    = sat(m_cor[i] + 1, cmax[i]);
              m_hit[i][l] = sat(m_hit[i][l] + 1, cmax[i]);
            end
          end
          if (m_tot[i] == m_len[i]) m_st[i] = 2;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] a_idx, a_tot, a_cor, a_inv, a_seen, a_hits, a_busy, a_done, a_st;
      int rc, e_seen, e_hits;
      if (i == 0) begin
        a_idx = 32'(o0_idx); a_tot = 32'(o0_tot); a_cor = 32'(o0_cor); a_inv = 32'(o0_inv);
        a_seen = 32'(o0_seen); a_hits = 32'(o0_hits); a_busy = 32'(o0_busy);
        a_done = 32'(o0_done); a_st = 32'(o0_st);
      end else begin
        a_idx = 32'(o1_idx); a_tot = 32'(o1_tot); a_cor = 32'(o1_cor); a_inv = 32'(o1_inv);
        a_seen = 32'(o1_seen); a_hits = 32'(o1_hits); a_busy = 32'(o1_busy);
        a_done = 32'(o1_done); a_st = 32'(o1_st);
      end
      rc     = int'(rdc_v[i]);
      e_seen = (rc < 10) ? m_seen[i][rc] : 0;
      e_hits = (rc < 10) ? m_hit[i][rc]  : 0;
      chk($sformatf("d%0d.sample_idx", i),    a_idx,  m_idx[i]);
      chk($sformatf("d%0d.total_count", i),   a_tot,  m_tot[i]);
      chk($sformatf("d%0d.correct_count", i), a_cor,  m_cor[i]);
      chk($sformatf("d%0d.invalid_count", i), a_inv,  m_inv[i]);
      chk($sformatf("d%0d.rd_seen", i),       a_seen, e_seen);
      chk($sformatf("d%0d.rd_hits", i),       a_hits, e_hits);
      chk($sformatf("d%0d.busy", i),          a_busy, (m_st[i] == 1) ? 1 : 0);
      chk($sformatf("d%0d.done", i),          a_done, (m_st[i] == 2) ? 1 : 0);
      chk($sformatf("d%0d.state", i),         a_st,   m_st[i]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int i, int n);
    start_v[i] = 1'b1;
    ns_v[i]    = 10'(n);
    tick();
    start_v[i] = 1'b0;
  endtask

  task automatic send(int i, int r, int l);
    bd_v[i]  = 1'b1;
    res_v[i] = 4'(r);
    lab_v[i] = 4'(l);
    tick();
    bd_v[i]  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; bd_v[i] = 1'b0; ns_v[i] = '0;
      res_v[i] = '0; lab_v[i] = '0; rdc_v[i] = '0;
    end

    // reset held: batch_done must not score
    repeat (2) send(0, 3, 3);
    chk("reset.total", 32'(o0_tot), 0);
    chk("reset.done", 32'(o0_done), 0);
    rst = 1'b1;
    tick();
    send(0, 3, 3);
    chk("idle.total_after_bd", 32'(o0_tot), 0);

    // basic run
    do_start(0, 4);
    send(0, 1, 1); send(0, 2, 5); send(0, 7, 7); send(0, 0, 0);
    chk("basic.total", 32'(o0_tot), 4);
    chk("basic.correct", 32'(o0_cor), 3);
    chk("basic.invalid", 32'(o0_inv), 0);
    chk("basic.done", 32'(o0_done), 1);
    chk("basic.busy", 32'(o0_busy), 0);
    rdc_v[0] = 4'd5; #1;
    chk("basic.seen5", 32'(o0_seen), 1);
    chk("basic.hits5", 32'(o0_hits), 0);
    rdc_v[0] = 4'd7; #1;
    chk("basic.seen7", 32'(o0_seen), 1);
    chk("basic.hits7", 32'(o0_hits), 1);
    tick();

    // invalid codes
    do_start(0, 3);
    send(0, 12, 2); send(0, 4, 11); send(0, 4, 4);
    chk("inv.invalid", 32'(o0_inv), 2);
    chk("inv.correct", 32'(o0_cor), 1);
    chk("inv.total", 32'(o0_tot), 3);
    rdc_v[0] = 4'd4; #1;
    chk("inv.seen4", 32'(o0_seen), 1);
    chk("inv.hits4", 32'(o0_hits), 1);
    rdc_v[0] = 4'd12; #1;
    chk("inv.seen12", 32'(o0_seen), 0);
    rdc_v[0] = 4'd2; #1;
    chk("inv.seen2", 32'(o0_seen), 0);
    tick();

    // zero length, then ignored batch_done in DONE
    do_start(0, 0);
    chk("zero.done", 32'(o0_done), 1);
    send(0, 1, 1); send(0, 2, 2);
    chk("zero.total", 32'(o0_tot), 0);

    // restart priority and async reset
    do_start(0, 10);
    send(0, 1, 1); send(0, 3, 3);
    chk("rst_run.total2", 32'(o0_tot), 2);
    start_v[0] = 1'b1; ns_v[0] = 10'd10;
    bd_v[0] = 1'b1; res_v[0] = 4'd5; lab_v[0] = 4'd5;
    tick();
    start_v[0] = 1'b0; bd_v[0] = 1'b0;
    chk("restart.total", 32'(o0_tot), 0);
    chk("restart.busy", 32'(o0_busy), 1);
    chk("restart.idx", 32'(o0_idx), 0);
    send(0, 6, 6);
    chk("restart.total1", 32'(o0_tot), 1);
    chk("restart.idx1", 32'(o0_idx), 1);
    #1 rst = 1'b0;
    #1;
    chk("async.total", 32'(o0_tot), 0);
    chk("async.idx", 32'(o0_idx), 0);
    chk("async.busy", 32'(o0_busy), 0);
    tick();
    rst = 1'b1;
    send(0, 6, 6);
    chk("async.no_score", 32'(o0_tot), 0);

    // narrow counters at full scale
    do_start(1, 7);
    for (int k = 0; k < 7; k++) send(1, 2, 2);
    rdc_v[1] = 4'd2; #1;
    chk("sat.correct", 32'(o1_cor), 7);
    chk("sat.seen2", 32'(o1_seen), 7);
    chk("sat.done", 32'(o1_done), 1);
    send(1, 2, 2);
    chk("sat.hold", 32'(o1_tot), 7);
    do_start(1, 7);
    chk("sat.restart_total", 32'(o1_tot), 0);
    chk("sat.restart_busy", 32'(o1_busy), 1);
    send(1, 9, 2);
    chk("sat.restart_total1", 32'(o1_tot), 1);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
